// File: rtl/free_list_pkg.sv
// Shared types, sizes and helpers for the rename-stage physical register free list.
// Pointer arithmetic wraps at DEPTH, which is not a power of two.
package free_list_pkg;

    localparam int PR_W   = 6;
    localparam int NUM_PR = 64;
    localparam int NUM_AR = 16;
    localparam int DEPTH  = NUM_PR - NUM_AR;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = 7;

    localparam logic [PTR_W:0] DEPTH_W = DEPTH[PTR_W:0];

    typedef logic [PR_W-1:0]  pr_num_t;
    typedef logic [PTR_W-1:0] fl_ptr_t;
    typedef logic [CNT_W-1:0] fl_cnt_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
    endfunction

    // ptr + n can exceed DEPTH by at most 4, so one conditional subtract wraps it
    function automatic fl_ptr_t ptr_add(input fl_ptr_t ptr, input logic [2:0] n);
        logic [PTR_W:0] sum;
        sum = {1'b0, ptr} + {{(PTR_W-2){1'b0}}, n};
        if (sum >= DEPTH_W) begin
            sum = sum - DEPTH_W;
        end
        return sum[PTR_W-1:0];
    endfunction

endpackage

// File: rtl/free_list_compact4.sv
// Packs the valid, non-zero released PRs of up to four retire slots into the
// low positions of the output, preserving slot order, and counts them.
module free_list_compact4
    import free_list_pkg::*;
(
    input  logic [3:0]      rel_valid,
    input  logic [PR_W-1:0] rel_pr [4],
    output logic [PR_W-1:0] packed_pr [4],
    output logic [2:0]      n_rel
);

    logic [3:0] live;
    logic [1:0] slot;

    // PR 0 means "no destination", so it is never returned to the list
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            live[k] = rel_valid[k] && (rel_pr[k] != '0);
        end
    end

    always_comb begin
        packed_pr = '{default: '0};
        slot      = '0;
        for (int k = 0; k < 4; k++) begin
            if (live[k]) begin
                packed_pr[slot] = rel_pr[k];
                slot            = slot + 2'd1;
            end
        end
    end

    assign n_rel = popcount4(live);

endmodule

// File: rtl/free_list.sv
// Physical register free list: hands out up to four PRs per cycle to rename,
// takes back up to four from retirement, and rolls back on flush.
module free_list
    import free_list_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      pr_need_list_in,
    input  logic            alloc_en,
    output logic [PR_W-1:0] pr_num_out0,
    output logic [PR_W-1:0] pr_num_out1,
    output logic [PR_W-1:0] pr_num_out2,
    output logic [PR_W-1:0] pr_num_out3,
    output logic            pr_avail,
    input  logic [3:0]      rel_valid,
    input  logic [PR_W-1:0] rel_pr0,
    input  logic [PR_W-1:0] rel_pr1,
    input  logic [PR_W-1:0] rel_pr2,
    input  logic [PR_W-1:0] rel_pr3,
    input  logic [2:0]      commit_alloc_cnt,
    input  logic            flush,
    output logic [6:0]      fl_count
);

    pr_num_t entry [DEPTH];
    fl_ptr_t head;
    fl_ptr_t tail;
    fl_ptr_t commit_head;
    fl_cnt_t count;
    fl_cnt_t inflight;

    logic [2:0] n_need;
    logic [2:0] n_alloc;
    logic [2:0] n_rel;
    logic       alloc_fire;
    logic [2:0] slot_off [4];
    pr_num_t    alloc_pr [4];
    pr_num_t    rel_pr [4];
    pr_num_t    rel_packed [4];
    fl_ptr_t    commit_head_next;
    fl_cnt_t    n_alloc_w;
    fl_cnt_t    n_rel_w;
    fl_cnt_t    commit_w;

    assign n_need     = popcount4(pr_need_list_in);
    assign pr_avail   = count >= {4'b0, n_need};
    assign alloc_fire = alloc_en && pr_avail && !flush;
    assign n_alloc    = alloc_fire ? n_need : 3'd0;

    assign n_alloc_w  = {4'b0, n_alloc};
    assign n_rel_w    = {4'b0, n_rel};
    assign commit_w   = {4'b0, commit_alloc_cnt};

    assign commit_head_next = ptr_add(commit_head, commit_alloc_cnt);

    // Slot k reads the entry past the PRs taken by lower-numbered needy slots
    always_comb begin
        slot_off[0] = 3'd0;
        slot_off[1] = {2'b0, pr_need_list_in[0]};
        slot_off[2] = popcount4({2'b0, pr_need_list_in[1:0]});
        slot_off[3] = popcount4({1'b0, pr_need_list_in[2:0]});
        for (int k = 0; k < 4; k++) begin
            alloc_pr[k] = pr_need_list_in[k] ? entry[ptr_add(head, slot_off[k])] : '0;
        end
    end

    assign pr_num_out0 = alloc_pr[0];
    assign pr_num_out1 = alloc_pr[1];
    assign pr_num_out2 = alloc_pr[2];
    assign pr_num_out3 = alloc_pr[3];
    assign fl_count    = count;

    assign rel_pr = '{rel_pr0, rel_pr1, rel_pr2, rel_pr3};

    free_list_compact4 u_compact (
        .rel_valid (rel_valid),
        .rel_pr    (rel_pr),
        .packed_pr (rel_packed),
        .n_rel     (n_rel)
    );

    // Released PRs land at tail; allocation reads them no earlier than next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= pr_num_t'(NUM_AR + i);
            end
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (3'(j) < n_rel) begin
                    entry[ptr_add(tail, 3'(j))] <= rel_packed[j];
                end
            end
        end
    end

    // Flush rewinds head to the committed point and returns in-flight PRs to the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            commit_head <= '0;
            count       <= fl_cnt_t'(DEPTH);
            inflight    <= '0;
        end else begin
            tail        <= ptr_add(tail, n_rel);
            commit_head <= commit_head_next;
            if (flush) begin
                head     <= commit_head_next;
                count    <= count + n_rel_w + inflight - commit_w;
                inflight <= '0;
            end else begin
                head     <= ptr_add(head, n_alloc);
                count    <= count - n_alloc_w + n_rel_w;
                inflight <= inflight + n_alloc_w - commit_w;
            end
        end
    end

    a_commit_le_inflight : assert property (@(posedge clk) disable iff (rst)
        commit_w <= inflight);

    a_count_le_depth : assert property (@(posedge clk) disable iff (rst)
        count <= fl_cnt_t'(DEPTH));

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: a queue-based model predicts each cycle's
// outputs, which are pushed when stimulus is driven and popped when sampled.
module tb_free_list;
    import free_list_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] need;
    logic       alloc_en;
    logic [5:0] pr_num_out0, pr_num_out1, pr_num_out2, pr_num_out3;
    logic       pr_avail;
    logic [3:0] rel_valid;
    logic [5:0] rel_pr0, rel_pr1, rel_pr2, rel_pr3;
    logic [2:0] cc;
    logic       flush;
    logic [6:0] fl_count;

    always #5 clk = ~clk;

    free_list dut (
        .clk              (clk),
        .rst              (rst),
        .pr_need_list_in  (need),
        .alloc_en         (alloc_en),
        .pr_num_out0      (pr_num_out0),
        .pr_num_out1      (pr_num_out1),
        .pr_num_out2      (pr_num_out2),
        .pr_num_out3      (pr_num_out3),
        .pr_avail         (pr_avail),
        .rel_valid        (rel_valid),
        .rel_pr0          (rel_pr0),
        .rel_pr1          (rel_pr1),
        .rel_pr2          (rel_pr2),
        .rel_pr3          (rel_pr3),
        .commit_alloc_cnt (cc),
        .flush            (flush),
        .fl_count         (fl_count)
    );

    typedef struct packed {
        logic [3:0][5:0] outs;
        logic            avail;
        logic [6:0]      cnt;
        logic [3:0]      need;
    } exp_t;

    exp_t       exp_q [$];
    logic [5:0] fl_q [$];
    logic [5:0] spec_q [$];
    int         checks   = 0;
    int         failures = 0;

    task automatic model_reset();
        fl_q.delete();
        spec_q.delete();
        exp_q.delete();
        for (int i = 0; i < 48; i++) fl_q.push_back(6'(16 + i));
    endtask

    // Drive one cycle's inputs and push the model's prediction for it
    task automatic step(input logic [3:0] nd, input logic en, input logic [3:0] rv,
                        input logic [5:0] p0, input logic [5:0] p1, input logic [5:0] p2,
                        input logic [5:0] p3, input logic [2:0] c, input logic f);
        exp_t e;
        int   idx;
        need = nd; alloc_en = en; rel_valid = rv;
        rel_pr0 = p0; rel_pr1 = p1; rel_pr2 = p2; rel_pr3 = p3;
        cc = c; flush = f;
        e = '0;
        e.need = nd;
        e.cnt  = 7'(fl_q.size());
        idx = 0;
        for (int k = 0; k < 4; k++) begin
            if (nd[k]) begin
                if (idx < fl_q.size()) e.outs[k] = fl_q[idx];
                idx++;
            end
        end
        e.avail = (fl_q.size() >= idx);
        exp_q.push_back(e);
        #1;
    endtask

    // Apply the clock edge to the model, then move to the next falling edge
    task automatic advance();
        logic [5:0] rel [$];
        logic [5:0] p [4];
        int         n;
        p = '{rel_pr0, rel_pr1, rel_pr2, rel_pr3};
        n = 0;
        for (int k = 0; k < 4; k++) if (need[k]) n++;
        if (!flush && alloc_en && fl_q.size() >= n)
            repeat (n) spec_q.push_back(fl_q.pop_front());
        for (int k = 0; k < 4; k++) if (rel_valid[k] && p[k] != '0) rel.push_back(p[k]);
        repeat (cc) if (spec_q.size() > 0) void'(spec_q.pop_front());
        if (flush) begin
            for (int i = spec_q.size() - 1; i >= 0; i--) fl_q.push_front(spec_q[i]);
            spec_q.delete();
        end
        foreach (rel[i]) fl_q.push_back(rel[i]);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        step(4'b0, 1'b0, 4'b0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t            e;
        logic [3:0][5:0] o;
        rst = 1'b1;
        model_reset();
        for (int t = 0; t < 3; t++) begin
            step(t == 2 ? 4'b0001 : 4'b1011, 1'b1, 4'b0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b0);
            e = exp_q.pop_front();
            o = {pr_num_out3, pr_num_out2, pr_num_out1, pr_num_out0};
            checks++;
            if (fl_count !== e.cnt) begin
                failures++;
                $display("[TB] FAIL reset_count t=%0d got=%0d exp=%0d", t, fl_count, e.cnt);
            end
            checks++;
            if (pr_avail !== e.avail) begin
                failures++;
                $display("[TB] FAIL reset_avail t=%0d got=%0b exp=%0b", t, pr_avail, e.avail);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (o[k] !== e.outs[k]) begin
                    failures++;
                    $display("[TB] FAIL reset_out%0d t=%0d got=%0d exp=%0d", k, t, o[k], e.outs[k]);
                end
            end
            if (t == 0) begin
                checks++;
                if (o !== {6'd18, 6'd0, 6'd17, 6'd16}) begin
                    failures++;
                    $display("[TB] FAIL reset_first_group got=%h exp=%h", o, {6'd18, 6'd0, 6'd17, 6'd16});
                end
                @(negedge clk);
                rst = 1'b0;
            end else if (t == 1) begin
                advance();
            end else begin
                checks++;
                if (fl_count !== 7'd45 || pr_num_out0 !== 6'd19) begin
                    failures++;
                    $display("[TB] FAIL reset_after_alloc got=%0d/%0d exp=45/19", fl_count, pr_num_out0);
                end
            end
        end
    endtask

    task automatic test_drain();
        exp_t            e;
        logic [3:0][5:0] o;
        do_reset();
        for (int t = 0; t < 14; t++) begin
            step(t < 12 ? 4'b1111 : (t == 12 ? 4'b0001 : 4'b0000), 1'b1,
                 4'b0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b0);
            e = exp_q.pop_front();
            o = {pr_num_out3, pr_num_out2, pr_num_out1, pr_num_out0};
            checks++;
            if (fl_count !== e.cnt || pr_avail !== e.avail) begin
                failures++;
                $display("[TB] FAIL drain_state t=%0d got=%0d/%0b exp=%0d/%0b",
                         t, fl_count, pr_avail, e.cnt, e.avail);
            end
            for (int k = 0; k < 4; k++) begin
                if (!e.need[k] || e.avail) begin
                    checks++;
                    if (o[k] !== e.outs[k]) begin
                        failures++;
                        $display("[TB] FAIL drain_out%0d t=%0d got=%0d exp=%0d", k, t, o[k], e.outs[k]);
                    end
                end
            end
            if (t == 12) begin
                checks++;
                if (pr_avail !== 1'b0 || fl_count !== 7'd0) begin
                    failures++;
                    $display("[TB] FAIL drain_empty got=%0b/%0d exp=0/0", pr_avail, fl_count);
                end
            end
            advance();
        end
    endtask

    // Continues from the empty list left by test_drain
    task automatic test_partial();
        exp_t            e;
        logic [3:0][5:0] o;
        for (int t = 0; t < 3; t++) begin
            case (t)
                0: step(4'b0000, 1'b0, 4'b0011, 6'd20, 6'd21, 6'd0, 6'd0, 3'd0, 1'b0);
                1: step(4'b0111, 1'b1, 4'b0111, 6'd5, 6'd6, 6'd7, 6'd0, 3'd0, 1'b0);
                default: step(4'b0111, 1'b1, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b0);
            endcase
            e = exp_q.pop_front();
            o = {pr_num_out3, pr_num_out2, pr_num_out1, pr_num_out0};
            checks++;
            if (fl_count !== e.cnt || pr_avail !== e.avail) begin
                failures++;
                $display("[TB] FAIL partial_state t=%0d got=%0d/%0b exp=%0d/%0b",
                         t, fl_count, pr_avail, e.cnt, e.avail);
            end
            for (int k = 0; k < 4; k++) begin
                if (!e.need[k] || e.avail) begin
                    checks++;
                    if (o[k] !== e.outs[k]) begin
                        failures++;
                        $display("[TB] FAIL partial_out%0d t=%0d got=%0d exp=%0d", k, t, o[k], e.outs[k]);
                    end
                end
            end
            if (t == 2) begin
                checks++;
                if (o !== {6'd0, 6'd5, 6'd21, 6'd20} || fl_count !== 7'd5) begin
                    failures++;
                    $display("[TB] FAIL partial_resume got=%h/%0d exp=%h/5", o, fl_count, {6'd0, 6'd5, 6'd21, 6'd20});
                end
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        exp_t            e;
        logic [3:0][5:0] o;
        logic [5:0]      b;
        do_reset();
        for (int t = 0; t < 26; t++) begin
            b = 6'(4 * t + 1);
            if (t < 11)       step(4'b1111, 1'b1, 4'b1111, b, b + 6'd1, b + 6'd2, b + 6'd3, 3'd0, 1'b0);
            else if (t == 11) step(4'b0111, 1'b1, 4'b0111, b, b + 6'd1, b + 6'd2, 6'd0, 3'd0, 1'b0);
            else if (t == 12) step(4'b0011, 1'b1, 4'b1010, 6'd0, 6'd9, 6'd0, 6'd12, 3'd0, 1'b0);
            else if (t == 13) step(4'b0000, 1'b0, 4'b0001, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b0);
            else              step(4'b1111, 1'b1, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b0);
            e = exp_q.pop_front();
            o = {pr_num_out3, pr_num_out2, pr_num_out1, pr_num_out0};
            checks++;
            if (fl_count !== e.cnt || pr_avail !== e.avail) begin
                failures++;
                $display("[TB] FAIL wrap_state t=%0d got=%0d/%0b exp=%0d/%0b",
                         t, fl_count, pr_avail, e.cnt, e.avail);
            end
            for (int k = 0; k < 4; k++) begin
                if (!e.need[k] || e.avail) begin
                    checks++;
                    if (o[k] !== e.outs[k]) begin
                        failures++;
                        $display("[TB] FAIL wrap_out%0d t=%0d got=%0d exp=%0d", k, t, o[k], e.outs[k]);
                    end
                end
            end
            advance();
        end
    endtask

    task automatic test_flush();
        exp_t            e;
        logic [3:0][5:0] o;
        do_reset();
        for (int t = 0; t < 5; t++) begin
            case (t)
                0, 1: step(4'b1111, 1'b1, 4'b0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b0);
                2:    step(4'b0000, 1'b0, 4'b0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd3, 1'b0);
                3:    step(4'b1111, 1'b1, 4'b0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd1, 1'b1);
                default: step(4'b0001, 1'b1, 4'b0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b0);
            endcase
            e = exp_q.pop_front();
            o = {pr_num_out3, pr_num_out2, pr_num_out1, pr_num_out0};
            checks++;
            if (fl_count !== e.cnt || pr_avail !== e.avail) begin
                failures++;
                $display("[TB] FAIL flush_state t=%0d got=%0d/%0b exp=%0d/%0b",
                         t, fl_count, pr_avail, e.cnt, e.avail);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (o[k] !== e.outs[k]) begin
                    failures++;
                    $display("[TB] FAIL flush_out%0d t=%0d got=%0d exp=%0d", k, t, o[k], e.outs[k]);
                end
            end
            if (t == 4) begin
                checks++;
                if (fl_count !== 7'd44 || pr_num_out0 !== 6'd20) begin
                    failures++;
                    $display("[TB] FAIL flush_recover got=%0d/%0d exp=44/20", fl_count, pr_num_out0);
                end
            end
            advance();
        end
    endtask

    // Legal random traffic: commits never exceed in-flight, total PRs never exceed DEPTH
    task automatic test_random();
        exp_t            e;
        logic [3:0][5:0] o;
        logic [3:0]      rv;
        logic [5:0]      p [4];
        logic [2:0]      c;
        int              room, nrel, cmax;
        do_reset();
        for (int t = 0; t < 300; t++) begin
            cmax = spec_q.size() < 4 ? spec_q.size() : 4;
            c    = 3'($urandom_range(cmax, 0));
            room = 48 - fl_q.size() - spec_q.size() + int'(c);
            rv   = 4'($urandom);
            nrel = 0;
            for (int k = 0; k < 4; k++) begin
                p[k] = ($urandom_range(7, 0) == 0) ? 6'd0 : 6'($urandom_range(63, 1));
                if (rv[k] && p[k] != '0) begin
                    if (nrel < room) nrel++;
                    else rv[k] = 1'b0;
                end
            end
            step(4'($urandom), 1'($urandom), rv, p[0], p[1], p[2], p[3], c,
                 $urandom_range(9, 0) == 0);
            e = exp_q.pop_front();
            o = {pr_num_out3, pr_num_out2, pr_num_out1, pr_num_out0};
            checks++;
            if (fl_count !== e.cnt || pr_avail !== e.avail) begin
                failures++;
                $display("[TB] FAIL random_state t=%0d got=%0d/%0b exp=%0d/%0b",
                         t, fl_count, pr_avail, e.cnt, e.avail);
            end
            for (int k = 0; k < 4; k++) begin
                if (!e.need[k] || e.avail) begin
                    checks++;
                    if (o[k] !== e.outs[k]) begin
                        failures++;
                        $display("[TB] FAIL random_out%0d t=%0d got=%0d exp=%0d", k, t, o[k], e.outs[k]);
                    end
                end
            end
            advance();
        end
    endtask

    // Reset arrives between clock edges on top of whatever test_random left behind
    task automatic test_midreset();
        exp_t            e;
        logic [3:0][5:0] o;
        #2;
        rst = 1'b1;
        model_reset();
        for (int t = 0; t < 4; t++) begin
            if (t == 2) begin
                @(negedge clk);
                rst = 1'b0;
            end
            step(t == 1 ? 4'b1011 : 4'b0001, t >= 2, 4'b0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b0);
            e = exp_q.pop_front();
            o = {pr_num_out3, pr_num_out2, pr_num_out1, pr_num_out0};
            checks++;
            if (fl_count !== e.cnt || pr_avail !== e.avail) begin
                failures++;
                $display("[TB] FAIL midreset_state t=%0d got=%0d/%0b exp=%0d/%0b",
                         t, fl_count, pr_avail, e.cnt, e.avail);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (o[k] !== e.outs[k]) begin
                    failures++;
                    $display("[TB] FAIL midreset_out%0d t=%0d got=%0d exp=%0d", k, t, o[k], e.outs[k]);
                end
            end
            if (t == 0) begin
                checks++;
                if (fl_count !== 7'd48 || pr_num_out0 !== 6'd16) begin
                    failures++;
                    $display("[TB] FAIL midreset_immediate got=%0d/%0d exp=48/16", fl_count, pr_num_out0);
                end
            end
            if (t >= 2) advance();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        need = '0; alloc_en = 1'b0; rel_valid = '0; cc = '0; flush = 1'b0;
        rel_pr0 = '0; rel_pr1 = '0; rel_pr2 = '0; rel_pr3 = '0;
        test_reset();
        test_drain();
        test_partial();
        test_wrap();
        test_flush();
        test_random();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
